knowles_sub_pipe: RTL and testbench
===================================

# knowles_sub_pipe

Pipelined 16-bit Kogge-Stone (Knowles) prefix subtractor with valid/ready handshakes on both sides. Computes a − b as a + ~b + 1 with a carry-in of 1, and reports unsigned borrow and signed overflow. It is the subtract counterpart of the 16-bit prefix adder in the FIR datapath, used for differencing and symmetric-tap pre-subtraction. It sustains one result per cycle with elastic back-pressure.

## Interface
- No parameters; width is fixed at 16.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- a  in  16  minuend
- b  in  16  subtrahend
- in_valid  in  1  a/b valid
- in_ready  out  1  block can accept a/b this cycle
- diff  out  16  (a − b) mod 2^16
- borrow  out  1  1 when a < b (unsigned); equals ~carry_out
- ovf  out  1  signed two's-complement overflow
- out_valid  out  1  diff/borrow/ovf valid
- out_ready  in  1  consumer accepts the result this cycle

## Operation
- Clock is clk. Reset is rst_n, synchronous and active-low.
- Pre-compute, registered in stage S1:
  - bb = ~b
  - p = a ^ bb
  - g = a & bb
  - cin = 1 is injected as g[−1], so the carry into bit 0 is 1.
- Prefix network uses Kogge-Stone levels at spans 1, 2, 4 and 8.
  - Black cells compute G = Gh | (Ph & Gl) and P = Ph & Pl.
  - Grey cells compute G only, on the column that reaches bit 0.
- Stage S2, macro on only: registers G/P after levels 1 and 2.
- Stage S3, the output register, holds the results of levels 3 and 4 plus post-compute:
  - diff[i] = p[i] ^ c[i], with c[0] = 1
  - borrow = ~c[16]
  - ovf = (a[15] ^ b[15]) & (a[15] ^ diff[15])
- a[15] and b[15] are carried through the pipeline for the ovf term.
- Each stage k holds a valid bit v_k. Stage k loads when !v_k || ready_{k+1}.
  - ready for S3 is out_ready.
  - in_ready = !v_S1 || ready_S2.
  - The ready path is combinational. There are no skid buffers.
- A transfer occurs on a rising edge where valid && ready. No operand is dropped or duplicated.
- A stage that holds data and is stalled keeps its contents unchanged.

## Timing
- Reset (rst_n low at an edge):
  - all v_k = 0
  - out_valid = 0, diff = 0, borrow = 0, ovf = 0
  - in_ready = 0 while rst_n is low, and 1 in the first cycle after release
- Reset mid-operation discards all in-flight data. No stale out_valid appears afterwards.
- Latency, for an operand accepted at edge N with out_ready held high:
  - macro on: out_valid is high after edge N+2
  - macro off: out_valid is high after edge N+1
- Throughput is 1 result per cycle with no bubbles under continuous in_valid and out_ready.
- Back-pressure:
  - With out_ready low, the pipeline fills: 3 entries with the macro on, 2 with it off.
  - in_ready then goes low in the same cycle the last stage would overflow.
  - When out_ready rises, in_ready rises in that same cycle, because the ready path is combinational.
- Simultaneous output drain and input accept when full is legal and keeps the occupancy constant.
- All outputs are registered except in_ready.

## Configuration
- Macro: KNOWLES_SUB_MIDREG_EN.
- Defined:
  - S2 is present and registers G/P between the span-2 and span-4 levels.
  - Latency is 2 edges; capacity is 3 entries.
- Undefined:
  - All four prefix levels and post-compute sit between S1 and S3.
  - Latency is 1 edge; capacity is 2 entries.
  - The critical path is longer.
- Arithmetic results are identical in both builds.

## Test plan
- Basic: a=0x0005, b=0x0003 → diff=0x0002, borrow=0, ovf=0.
- Wrap/borrow:
  - a=0x0000, b=0x0001 → diff=0xFFFF, borrow=1, ovf=0.
  - a=0x1234, b=0x1234 → diff=0x0000, borrow=0.
- Signed overflow:
  - a=0x8000, b=0x0001 → diff=0x7FFF, borrow=0, ovf=1.
  - a=0x7FFF, b=0xFFFF → diff=0x8000, borrow=1, ovf=1.
- Streaming: 8 back-to-back random pairs with out_ready=1 → 8 consecutive out_valid cycles, each matching the reference a−b. First result arrives at the specified latency for each macro setting.
- Back-pressure: stream 6 pairs, hold out_ready=0 for 5 cycles, then release.
  - in_ready drops after 3 accepts (macro on) or 2 (macro off).
  - All 6 results emerge in order with no loss; diff/borrow/ovf stay stable while stalled.
- Reset mid-flight: assert rst_n=0 for 1 cycle with a full pipeline.
  - Next cycle: out_valid=0 and diff=0.
  - No pre-reset result ever appears.
  - First post-reset op, 0x0010−0x0020, gives diff=0xFFF0, borrow=1.

Source files
------------

// File: rtl/knowles_sub_pipe.sv
// knowles_sub_pipe: pipelined 16-bit Kogge-Stone prefix subtractor, diff = a - b.
// Computed as a + ~b + 1; the carry-in of 1 is folded into generate bit 0 in S1.
// Optional macro KNOWLES_SUB_MIDREG_EN inserts register stage S2 between the
// span-2 and span-4 prefix levels (latency 2, capacity 3); without it the whole
// prefix tree sits between S1 and S3 (latency 1, capacity 2).
// Handshake: a stage loads when it is empty or the next stage can load; a
// transfer happens on a rising edge where valid && ready; ready is combinational
// back to in_ready and there are no skid buffers.
module knowles_sub_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] diff,
    output logic        borrow,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    // S1 registers: propagate, generate (with carry-in folded into bit 0), sign bits
    logic        s1_v_q,   s1_v_d;
    logic [15:0] s1_p_q,   s1_p_d;
    logic [15:0] s1_g_q,   s1_g_d;
    logic        s1_a15_q, s1_a15_d;
    logic        s1_b15_q, s1_b15_d;

    // S3 registers: the visible outputs
    logic        s3_v_q,      s3_v_d;
    logic [15:0] s3_diff_q,   s3_diff_d;
    logic        s3_borrow_q, s3_borrow_d;
    logic        s3_ovf_q,    s3_ovf_d;

    // Prefix levels; P is only kept on bits where a later black cell consumes it
    logic [15:0] g_l1, g_l2, g_l3, g_l4;
    logic [15:2] p_l1;
    logic [15:4] p_l2;
    logic [15:8] p_l3;

    // Inputs to the back half of the tree (after S2 when present)
    logic [15:0] g_m;
    logic [15:4] p_m;
    logic [15:0] pp_m;
    logic        a15_m, b15_m, v_m;

    logic        load1, load3;
    logic [16:0] carry;
    logic [15:0] diff_n;

    assign load3 = !s3_v_q || out_ready;

    // Front half: spans 1 and 2 (grey cells pass P through on the bit-0 column)
    for (genvar i = 0; i < 16; i++) begin : g_front
        if (i >= 1) begin : g_l1_blk
            assign g_l1[i] = s1_g_q[i] | (s1_p_q[i] & s1_g_q[i-1]);
        end else begin : g_l1_pass
            assign g_l1[i] = s1_g_q[i];
        end
        if (i >= 2) begin : p_l1_blk
            assign p_l1[i] = s1_p_q[i] & s1_p_q[i-1];
            assign g_l2[i] = g_l1[i] | (p_l1[i] & g_l1[i-2]);
        end else begin : g_l2_pass
            assign g_l2[i] = g_l1[i];
        end
        if (i >= 4) begin : p_l2_blk
            assign p_l2[i] = p_l1[i] & p_l1[i-2];
        end
    end

`ifdef KNOWLES_SUB_MIDREG_EN
    logic        s2_v_q,   s2_v_d;
    logic [15:0] s2_g_q,   s2_g_d;
    logic [15:4] s2_p_q,   s2_p_d;
    logic [15:0] s2_pp_q,  s2_pp_d;
    logic        s2_a15_q, s2_a15_d;
    logic        s2_b15_q, s2_b15_d;
    logic        load2;

    assign load2 = !s2_v_q || load3;
    assign load1 = !s1_v_q || load2;

    // S2 next state: capture span-2 G/P plus the raw propagate for post-compute
    always_comb begin
        s2_v_d   = s2_v_q;
        s2_g_d   = s2_g_q;
        s2_p_d   = s2_p_q;
        s2_pp_d  = s2_pp_q;
        s2_a15_d = s2_a15_q;
        s2_b15_d = s2_b15_q;
        if (load2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_g_d   = g_l2;
                s2_p_d   = p_l2;
                s2_pp_d  = s1_p_q;
                s2_a15_d = s1_a15_q;
                s2_b15_d = s1_b15_q;
            end
        end
    end

    assign g_m   = s2_g_q;
    assign p_m   = s2_p_q;
    assign pp_m  = s2_pp_q;
    assign a15_m = s2_a15_q;
    assign b15_m = s2_b15_q;
    assign v_m   = s2_v_q;
`else
    assign load1 = !s1_v_q || load3;
    assign g_m   = g_l2;
    assign p_m   = p_l2;
    assign pp_m  = s1_p_q;
    assign a15_m = s1_a15_q;
    assign b15_m = s1_b15_q;
    assign v_m   = s1_v_q;
`endif

    assign in_ready = rst_n && load1;

    // Back half: spans 4 and 8
    for (genvar i = 0; i < 16; i++) begin : g_back
        if (i >= 4) begin : g_l3_blk
            assign g_l3[i] = g_m[i] | (p_m[i] & g_m[i-4]);
        end else begin : g_l3_pass
            assign g_l3[i] = g_m[i];
        end
        if (i >= 8) begin : g_l4_blk
            assign p_l3[i] = p_m[i] & p_m[i-4];
            assign g_l4[i] = g_l3[i] | (p_l3[i] & g_l3[i-8]);
        end else begin : g_l4_pass
            assign g_l4[i] = g_l3[i];
        end
    end

    // c[0] = 1 (carry-in), c[i+1] = group generate over bits [i:0]
    assign carry  = {g_l4, 1'b1};
    assign diff_n = pp_m ^ carry[15:0];

    // S1 next state: pre-compute with bb = ~b; g[0] absorbs the carry-in
    always_comb begin
        s1_v_d   = s1_v_q;
        s1_p_d   = s1_p_q;
        s1_g_d   = s1_g_q;
        s1_a15_d = s1_a15_q;
        s1_b15_d = s1_b15_q;
        if (load1) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_p_d    = a ^ ~b;
                s1_g_d    = a & ~b;
                s1_g_d[0] = a[0] | ~b[0];
                s1_a15_d  = a[15];
                s1_b15_d  = b[15];
            end
        end
    end

    // S3 next state: post-compute diff, borrow and signed overflow
    always_comb begin
        s3_v_d      = s3_v_q;
        s3_diff_d   = s3_diff_q;
        s3_borrow_d = s3_borrow_q;
        s3_ovf_d    = s3_ovf_q;
        if (load3) begin
            s3_v_d = v_m;
            if (v_m) begin
                s3_diff_d   = diff_n;
                s3_borrow_d = ~carry[16];
                s3_ovf_d    = (a15_m ^ b15_m) & (a15_m ^ diff_n[15]);
            end
        end
    end

    // All pipeline state; synchronous active-low reset clears everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_p_q      <= '0;
            s1_g_q      <= '0;
            s1_a15_q    <= 1'b0;
            s1_b15_q    <= 1'b0;
`ifdef KNOWLES_SUB_MIDREG_EN
            s2_v_q      <= 1'b0;
            s2_g_q      <= '0;
            s2_p_q      <= '0;
            s2_pp_q     <= '0;
            s2_a15_q    <= 1'b0;
            s2_b15_q    <= 1'b0;
`endif
            s3_v_q      <= 1'b0;
            s3_diff_q   <= '0;
            s3_borrow_q <= 1'b0;
            s3_ovf_q    <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_p_q      <= s1_p_d;
            s1_g_q      <= s1_g_d;
            s1_a15_q    <= s1_a15_d;
            s1_b15_q    <= s1_b15_d;
`ifdef KNOWLES_SUB_MIDREG_EN
            s2_v_q      <= s2_v_d;
            s2_g_q      <= s2_g_d;
            s2_p_q      <= s2_p_d;
            s2_pp_q     <= s2_pp_d;
            s2_a15_q    <= s2_a15_d;
            s2_b15_q    <= s2_b15_d;
`endif
            s3_v_q      <= s3_v_d;
            s3_diff_q   <= s3_diff_d;
            s3_borrow_q <= s3_borrow_d;
            s3_ovf_q    <= s3_ovf_d;
        end
    end

    assign out_valid = s3_v_q;
    assign diff      = s3_diff_q;
    assign borrow    = s3_borrow_q;
    assign ovf       = s3_ovf_q;

endmodule

// File: tb/tb_knowles_sub_pipe.sv
// Bench for knowles_sub_pipe: reference model is plain 16-bit arithmetic;
// expected results are queued on input accept and popped on output transfer.
module tb_knowles_sub_pipe;

`ifdef KNOWLES_SUB_MIDREG_EN
  localparam int LAT = 2;
  localparam int CAP = 3;
`else
  localparam int LAT = 1;
  localparam int CAP = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] diff;
  logic        borrow;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int n_vec;
  int n_err;
  int acc_cnt;
  logic [17:0] exp_q[$];

  knowles_sub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // reference: {diff, borrow, ovf} from plain arithmetic
  function automatic logic [17:0] ref_sub(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] d;
    int sd;
    d  = x - y;
    sd = int'($signed(x)) - int'($signed(y));
    return {d, (x < y), (sd > 32767 || sd < -32768)};
  endfunction

  // scoreboard: sampled on the falling edge, transfers happen on the next rising edge
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 32'(diff), 32'hDEAD0000);
        end else begin
          e = exp_q.pop_front();
          check_val("sb_diff", 32'(diff), 32'(e[17:2]));
          check_val("sb_borrow", 32'(borrow), 32'(e[1]));
          check_val("sb_ovf", 32'(ovf), 32'(e[0]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sub(a, b));
        acc_cnt++;
      end
    end
  end

  // driver: present one operand pair and hold it until accepted
  task automatic send(input logic [15:0] x, input logic [15:0] y);
    int w;
    a = x;
    b = y;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check_val("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] dir_a [5] = '{16'h0005, 16'h0000, 16'h1234, 16'h8000, 16'h7FFF};
  logic [15:0] dir_b [5] = '{16'h0003, 16'h0001, 16'h1234, 16'h0001, 16'hFFFF};
  logic        rnd_done;

  initial begin
    int k;
    n_vec = 0;
    n_err = 0;
    acc_cnt = 0;
    rnd_done = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_diff", 32'(diff), 32'd0);
    check_val("rst_borrow", 32'(borrow), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // latency of a single operand into an empty pipeline
    send(16'h0005, 16'h0003);
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_val("latency", 32'(k), 32'(LAT));
    check_val("lat_diff", 32'(diff), 32'h0002);
    wait_drain();

    // directed corner cases (basic, wrap, equal, signed overflow both ways)
    for (int i = 0; i < 5; i++) send(dir_a[i], dir_b[i]);
    wait_drain();

    // streaming: 8 back-to-back pairs must give 8 consecutive results
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom));
      end
      begin : run_mon
        int w, run;
        w = 0;
        run = 0;
        while (!out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        while (out_valid && run < 20) begin
          run++;
          @(negedge clk);
        end
        check_val("stream_run", 32'(run), 32'd8);
      end
    join
    wait_drain();

    // back-pressure: fill, hold, release
    out_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom));
      end
      begin : bp_mon
        int w;
        w = 0;
        @(negedge clk);
        while (in_ready && w < 30) begin
          @(negedge clk);
          w++;
        end
        check_val("bp_fill_cnt", 32'(acc_cnt), 32'(CAP));
        for (int j = 0; j < 5; j++) begin
          check_val("bp_hold_valid", 32'(out_valid), 32'd1);
          check_val("bp_hold_diff", 32'(diff), 32'(exp_q[0][17:2]));
          check_val("bp_hold_in_ready", 32'(in_ready), 32'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 32'(in_ready), 32'd1);
      end
    join
    wait_drain();

    // reset with a full pipeline
    out_ready = 1'b0;
    for (int i = 0; i < CAP; i++) send(16'($urandom), 16'($urandom));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("rst_mid_valid", 32'(out_valid), 32'd0);
    check_val("rst_mid_diff", 32'(diff), 32'd0);
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_val("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(16'h0010, 16'h0020);
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_val("post_rst_diff", 32'(diff), 32'h0000FFF0);
    check_val("post_rst_borrow", 32'(borrow), 32'd1);
    wait_drain();

    // random traffic with random gaps and random back-pressure
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(16'($urandom), 16'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
